// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner: one anode per slot,
// leading blank window per slot, frame-wide input snapshot and blink gating.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 50
) (
    input  logic                    clk_one,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int SC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int FC_W  = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

    localparam logic [SC_W-1:0]  SC_MAX    = SC_W'(REFRESH_DIV - 1);
    localparam logic [SC_W-1:0]  BLANK_LIM = SC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(BLINK_DIV - 1);

    logic [SC_W-1:0]  sc;
    logic [IDX_W-1:0] idx;
    logic [FC_W-1:0]  fc;
    logic             bp;

    logic [4*NUM_DIGITS-1:0] snap_data;
    logic [NUM_DIGITS-1:0]   snap_en, snap_dp, snap_bm;

    logic                            cap;
    logic [NUM_DIGITS-1:0][3:0]      nib_arr;
    logic [NUM_DIGITS-1:0]           eff_en, eff_dp, eff_bm;
    logic [NUM_DIGITS-1:0]           an_sel;
    logic                            blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b1100000;
            4'hC:    decode = 7'b0110001;
            4'hD:    decode = 7'b1000010;
            4'hE:    decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk_one or posedge reset) begin
        if (reset) begin
            sc  <= '0;
            idx <= '0;
            fc  <= '0;
            bp  <= 1'b0;
        end else if (sc == SC_MAX) begin
            sc <= '0;
            if (idx == IDX_MAX) begin
                idx <= '0;
                if (fc == FC_MAX) begin
                    fc <= '0;
                    bp <= ~bp;
                end else begin
                    fc <= fc + 1'b1;
                end
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            sc <= sc + 1'b1;
        end
    end

    assign cap = (sc == '0) && (idx == '0);

    always_ff @(posedge clk_one or posedge reset) begin
        if (reset) begin
            snap_data <= '0;
            snap_en   <= '0;
            snap_dp   <= '0;
            snap_bm   <= '0;
        end else if (cap) begin
            snap_data <= digit_data;
            snap_en   <= digit_en;
            snap_dp   <= dp_in;
            snap_bm   <= blink_mask;
        end
    end

    // On the capture cycle the live inputs stand in for the snapshot, so the
    // first slot of a frame never shows the previous frame's values.
    assign nib_arr = cap ? digit_data : snap_data;
    assign eff_en  = cap ? digit_en   : snap_en;
    assign eff_dp  = cap ? dp_in      : snap_dp;
    assign eff_bm  = cap ? blink_mask : snap_bm;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_an
        assign an_sel[k] = (idx == IDX_W'(k));
    end

    assign blank = (sc < BLANK_LIM) || !eff_en[idx] || (bp && eff_bm[idx]);

    always_ff @(posedge clk_one or posedge reset) begin
        if (reset) begin
            an          <= '1;
            a_to_g      <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= cap;
            if (blank) begin
                an     <= '1;
                a_to_g <= 7'h7F;
                dp     <= 1'b1;
            end else begin
                an     <= ~an_sel;
                a_to_g <= decode(nib_arr[idx]);
                dp     <= ~eff_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg_scan_driver;

    logic        clk_one = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] digit_data = 16'h3210;
    logic [3:0]  digit_en   = 4'b1111;
    logic [3:0]  dp_in      = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;
    logic        frame_start;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_DIV(2)
    ) dut (
        .clk_one(clk_one), .reset(reset), .digit_data(digit_data),
        .digit_en(digit_en), .dp_in(dp_in), .blink_mask(blink_mask),
        .an(an), .a_to_g(a_to_g), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk_one = ~clk_one;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    always @(negedge clk_one) chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);

    // One 8-cycle slot: two blank cycles, then six with the given values.
    task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic dp_e, input logic fs_e);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_one);
            chk({tag, "_fs"}, frame_start, (i == 0) ? fs_e : 1'b0);
            if (i < 2) begin
                chk({tag, "_blk_an"}, an, 4'hF);
                chk({tag, "_blk_seg"}, a_to_g, 7'h7F);
                chk({tag, "_blk_dp"}, dp, 1'b1);
            end else begin
                chk({tag, "_an"}, an, an_e);
                chk({tag, "_seg"}, a_to_g, seg_e);
                chk({tag, "_dp"}, dp, dp_e);
            end
        end
    endtask

    // segs holds digit 0 in [6:0]; vis/dpx are per-digit visible / dp-lit.
    task automatic frame_chk(input string tag, input logic [27:0] segs,
                             input logic [3:0] vis, input logic [3:0] dpx);
        for (int d = 0; d < 4; d++) begin
            if (vis[d]) slot($sformatf("%s_d%0d", tag, d), an_tab[d], segs[7*d +: 7], ~dpx[d], d == 0);
            else        slot($sformatf("%s_d%0d", tag, d), 4'hF, 7'h7F, 1'b1, d == 0);
        end
    endtask

    localparam logic [27:0] SEG_3210 = {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
    localparam logic [27:0] SEG_F800 = {7'b0111000, 7'b0000000, 7'b0000001, 7'b0000001};
    localparam logic [27:0] SEG_4321 = {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    localparam logic [27:0] SEG_DCBA = {7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000};
    localparam logic [27:0] SEG_9765 = {7'b0000100, 7'b0001111, 7'b0100000, 7'b0100100};
    localparam logic [27:0] SEG_EEEE = {4{7'b0110000}};

    initial begin
        repeat (2) @(negedge clk_one);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", a_to_g, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fs", frame_start, 1'b0);
        reset = 1'b0;

        frame_chk("f0", SEG_3210, 4'b1111, 4'b0000);
        fork
            begin
                repeat (12) @(negedge clk_one);
                digit_data = 16'hF800;
            end
        join_none
        frame_chk("f1", SEG_3210, 4'b1111, 4'b0000);
        frame_chk("f2", SEG_F800, 4'b1111, 4'b0000);

        digit_en = 4'b1011;
        dp_in    = 4'b0001;
        frame_chk("f3", SEG_F800, 4'b1011, 4'b0001);

        digit_en   = 4'b1111;
        dp_in      = 4'b0000;
        digit_data = 16'h4321;
        blink_mask = 4'b0010;
        frame_chk("f4", SEG_4321, 4'b1111, 4'b0000);
        frame_chk("f5", SEG_4321, 4'b1111, 4'b0000);
        frame_chk("f6", SEG_4321, 4'b1101, 4'b0000);
        frame_chk("f7", SEG_4321, 4'b1101, 4'b0000);
        frame_chk("f8", SEG_4321, 4'b1111, 4'b0000);

        blink_mask = 4'b0000;
        digit_data = 16'hDCBA;
        frame_chk("f9", SEG_DCBA, 4'b1111, 4'b0000);
        digit_data = 16'h9765;
        frame_chk("f10", SEG_9765, 4'b1111, 4'b0000);
        digit_data = 16'hEEEE;
        frame_chk("f11", SEG_EEEE, 4'b1111, 4'b0000);

        digit_data = 16'h3210;
        slot("f12_d0", 4'b1110, 7'b0000001, 1'b1, 1'b1);
        slot("f12_d1", 4'b1101, 7'b1001111, 1'b1, 1'b0);
        repeat (4) @(negedge clk_one);
        chk("pre_rst_an", an, 4'b1011);
        chk("pre_rst_seg", a_to_g, 7'b0010010);
        reset = 1'b1;
        #1;
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", a_to_g, 7'h7F);
        chk("mid_rst_dp", dp, 1'b1);
        chk("mid_rst_fs", frame_start, 1'b0);
        @(negedge clk_one);
        reset = 1'b0;
        frame_chk("post_rst", SEG_3210, 4'b1111, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for the board's common-anode 8-digit seven-segment display.
- Consumes per-digit nibble values from the timer path and cycles one anode at a time.
- Decodes each nibble to active-low segments internally and blanks between digits to suppress ghosting.
- Replaces the fixed-anode display path so both timers and status can share one segment bus.

Parameters:
NUM_DIGITS, 8, number of anodes scanned (1..8)
REFRESH_DIV, 100000, clk_one cycles each digit slot lasts (>=2)
BLANK_CYCLES, 1000, cycles at start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)
BLINK_DIV, 50, full frames per blink phase toggle (>=1)

Ports:
clk_one  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
digit_data  input  4*NUM_DIGITS  nibble per digit; digit k = bits [4k+3:4k]
digit_en  input  NUM_DIGITS  1 = digit shown, 0 = digit dark
dp_in  input  NUM_DIGITS  1 = decimal point lit for digit k
blink_mask  input  NUM_DIGITS  1 = digit blanked while blink phase = 1
an  output  NUM_DIGITS  anode enables, active low
a_to_g  output  7  segments, active low; bit6 = a … bit0 = g
dp  output  1  decimal point, active low
frame_start  output  1  one-cycle pulse when the digit 0 slot begins

Behaviour:
- Reset (async, active-high) values:
  - an = all 1s; a_to_g = 7'h7F; dp = 1; frame_start = 0.
  - Slot counter sc = 0, digit index idx = 0, frame counter fc = 0, blink phase bp = 0.
  - Snapshot registers cleared to 0.
- Counters:
  - sc increments every cycle and wraps REFRESH_DIV-1 -> 0.
  - On wrap, idx increments and wraps NUM_DIGITS-1 -> 0.
  - On idx wrap, fc increments. When fc reaches BLINK_DIV-1 and wraps to 0, bp toggles.
- Snapshot:
  - When sc == 0 and idx == 0, latch digit_data, digit_en, dp_in and blink_mask into snapshot registers.
  - The whole frame displays the snapshot, so there is no tearing when inputs change mid-frame.
  - The first snapshot is taken on the first clock edge after reset deasserts.
- Outputs are registered, with one cycle of latency from counter state: values driven in cycle t+1 reflect sc/idx in cycle t.
- Per-slot output rules:
  - Blank when sc < BLANK_CYCLES, or the snapshot digit_en[idx] = 0, or (bp = 1 and the snapshot blink_mask[idx] = 1). Blank means an = all 1s, a_to_g = 7'h7F, dp = 1.
  - Otherwise an = ~(1 << idx), a_to_g = decode(nibble idx), dp = ~dp_in[idx].
- frame_start is registered 1 for exactly one cycle, aligned with the first output cycle of the digit 0 slot (sc == 0, idx == 0 the previous cycle).
- Decode table (gfedcba order inverted, active low, a_to_g[6:0] = a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Invariant: never more than one anode low in any cycle.
- Reset mid-slot: outputs go to their reset values immediately (async). Scan restarts at digit 0 with a fresh snapshot.
- Input changes between snapshots have no effect until the next frame.

Test Plan:
- Parameters for all tests: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=2.
- Reset release, digit_data=16'h3210, all enabled:
  - frame_start high 1 cycle after release.
  - an=1111 for 2 cycles, then an=1110 with a_to_g=0000001 for 6 cycles.
  - Then 2 blank cycles, then an=1101 with a_to_g=1001111; digits 2 and 3 follow the same pattern.
  - frame_start repeats every 32 cycles.
- Change digit_data to 16'hF800 in the middle of digit 1's slot:
  - Digits 2 and 3 still show 2 and 3 for the rest of that frame.
  - Next frame shows 0,0,8 (0000000),F (0111000).
- digit_en=4'b1011, dp_in=4'b0001:
  - Digit 2 slot keeps an=1111 for all 8 cycles.
  - dp=0 only during digit 0's unblanked cycles.
- blink_mask=4'b0010:
  - Digit 1 shows in frames 0–1, is dark in frames 2–3, and shows again in frames 4–5.
  - Other digits are unaffected.
- Assert reset for 1 cycle during digit 2's unblanked window:
  - an=1111 and a_to_g=7F immediately.
  - After release, frame_start pulses and digit 0 restarts with its 2-cycle blank.
- Over the whole run, a checker confirms an never has more than one 0 bit.
